sequence_stuff_tx: RTL and testbench

- Serial transmitter for the run-of-four sequence detector.
- Accepts bytes on a valid/ready handshake and frames them as follows:
  - start flag: four 1s, which fires the detector;
  - payload: sent MSB-first, with a complementary stuff bit after any run of 3 identical bits, so no run of 4 appears inside the payload;
  - end flag: four 0s, which fires the detector.
- Drives the detector's w input and provides a debug state display.

---
 rtl/sequence_pkg.sv | 33 +++
 rtl/stuff_run_tracker.sv | 57 +++++
 rtl/sequence_stuff_tx.sv | 216 +++++++++++++++++++++
 tb/tb_sequence_stuff_tx.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_pkg.sv
// Shared state encoding and display constants for the run-of-four framing transmitter.
package sequence_pkg;

    // Flag length; the stuff threshold is one less than this.
    localparam int unsigned DEF_FLAG_LEN = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SOF   = 3'd1,
        DATA  = 3'd2,
        STUFF = 3'd3,
        EOF   = 3'd4
    } state_e;

    localparam logic [3:0] LED_IDLE    = 4'b0001;
    localparam logic [3:0] LED_SOF     = 4'b0010;
    localparam logic [3:0] LED_PAYLOAD = 4'b0100;
    localparam logic [3:0] LED_EOF     = 4'b1000;

    // One-hot display code for a state; DATA and STUFF share the payload lamp.
    function automatic logic [3:0] state_led(input state_e s);
        logic [3:0] led;
        unique case (s)
            IDLE:        led = LED_IDLE;
            SOF:         led = LED_SOF;
            DATA, STUFF: led = LED_PAYLOAD;
            EOF:         led = LED_EOF;
            default:     led = LED_IDLE;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/stuff_run_tracker.sv
// Tracks the run length of identical emitted bits and requests a complementary
// stuff bit once the run reaches FLAG_LEN-1. Reusable on the receive side.
module stuff_run_tracker
    import sequence_pkg::*;
#(
    parameter int unsigned FLAG_LEN = DEF_FLAG_LEN
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bit,
    input  logic i_emit,
    input  logic i_clear,
    output logic o_prev_bit,
    output logic o_stuff_req
);

    localparam int unsigned RW      = $clog2(FLAG_LEN);
    localparam logic [RW-1:0] RUN_MAX = RW'(FLAG_LEN - 1);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);

    logic [RW-1:0] r_run_cnt;
    logic          r_prev_bit;
    logic [RW-1:0] w_run_d;
    logic          w_prev_d;

    // Next run length: a clear together with an emit starts a fresh run at that bit.
    always_comb begin
        w_run_d  = r_run_cnt;
        w_prev_d = r_prev_bit;
        if (i_emit) begin
            if (i_clear || (r_run_cnt == '0) || (i_bit != r_prev_bit)) begin
                w_run_d = RUN_ONE;
            end else begin
                w_run_d = r_run_cnt + 1'b1;
            end
            w_prev_d = i_bit;
        end else if (i_clear) begin
            w_run_d  = '0;
            w_prev_d = 1'b0;
        end
    end

    // Run state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run_cnt  <= '0;
            r_prev_bit <= 1'b0;
        end else begin
            r_run_cnt  <= w_run_d;
            r_prev_bit <= w_prev_d;
        end
    end

    assign o_prev_bit  = r_prev_bit;
    assign o_stuff_req = (r_run_cnt == RUN_MAX);

endmodule

// File: rtl/sequence_stuff_tx.sv
// Serial framing transmitter: start flag of ones, bit-stuffed MSB-first payload,
// end flag of zeros. State and w are registered together, so the state always
// describes the bit currently on w.
module sequence_stuff_tx
    import sequence_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned FLAG_LEN = DEF_FLAG_LEN
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              data_last,
    output logic              data_ready,
    output logic              w,
    output logic              w_valid,
    output logic              busy,
    output logic              err,
    output logic [7:4]        LEDR
);

    localparam int unsigned FCW = $clog2(FLAG_LEN + 1);
    localparam int unsigned BCW = $clog2(DATA_W + 1);
    localparam logic [FCW-1:0] FLAG_MAX = FCW'(FLAG_LEN);
    localparam logic [FCW-1:0] FLAG_ONE = FCW'(1);
    localparam logic [BCW-1:0] BIT_MAX  = BCW'(DATA_W);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

    state_e            r_state;
    logic [FCW-1:0]    r_flag_cnt;
    logic [DATA_W-1:0] r_sh;
    logic [BCW-1:0]    r_bit_cnt;
    logic              r_last;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_last;
    logic              r_hold_full;
    logic              r_w;
    logic              r_w_valid;
    logic              r_err;

    state_e            w_state_d;
    logic [FCW-1:0]    w_flag_cnt_d;
    logic [DATA_W-1:0] w_sh_d;
    logic [BCW-1:0]    w_bit_cnt_d;
    logic              w_last_d;
    logic              w_w_d;
    logic              w_valid_d;
    logic              w_err_d;
    logic              w_advance;
    logic              w_load;
    logic              w_emit;
    logic              w_emit_bit;
    logic              w_clear;
    logic              w_accept;
    logic              w_prev_bit;
    logic              w_stuff_req;

    // Ready is held low during reset; accept itself needs only the empty flag.
    assign data_ready = Reset && !r_hold_full;
    assign w_accept   = data_valid && !r_hold_full;

    stuff_run_tracker #(
        .FLAG_LEN (FLAG_LEN)
    ) u_tracker (
        .i_clk       (Clk),
        .i_rst_n     (Reset),
        .i_bit       (w_emit_bit),
        .i_emit      (w_emit),
        .i_clear     (w_clear),
        .o_prev_bit  (w_prev_bit),
        .o_stuff_req (w_stuff_req)
    );

    // Next state plus the bit that will sit on w during that state.
    always_comb begin
        w_state_d    = r_state;
        w_flag_cnt_d = r_flag_cnt;
        w_sh_d       = r_sh;
        w_bit_cnt_d  = r_bit_cnt;
        w_last_d     = r_last;
        w_w_d        = 1'b0;
        w_valid_d    = 1'b0;
        w_err_d      = 1'b0;
        w_advance    = 1'b0;
        w_load       = 1'b0;
        w_emit       = 1'b0;
        w_emit_bit   = 1'b0;
        w_clear      = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_state_d    = SOF;
                    w_flag_cnt_d = FLAG_ONE;
                    w_w_d        = 1'b1;
                    w_valid_d    = 1'b1;
                end
            end
            SOF: begin
                if (r_flag_cnt != FLAG_MAX) begin
                    w_flag_cnt_d = r_flag_cnt + 1'b1;
                    w_w_d        = 1'b1;
                    w_valid_d    = 1'b1;
                end else begin
                    // Flag ones must not count toward the payload run.
                    w_load  = 1'b1;
                    w_clear = 1'b1;
                end
            end
            DATA: begin
                if (w_stuff_req) begin
                    w_state_d  = STUFF;
                    w_w_d      = !w_prev_bit;
                    w_valid_d  = 1'b1;
                    w_emit     = 1'b1;
                    w_emit_bit = !w_prev_bit;
                end else begin
                    w_advance = 1'b1;
                end
            end
            STUFF: begin
                w_advance = 1'b1;
            end
            EOF: begin
                if (r_flag_cnt != FLAG_MAX) begin
                    w_flag_cnt_d = r_flag_cnt + 1'b1;
                    w_valid_d    = 1'b1;
                end else begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Next payload bit, or the word boundary decision.
        if (w_advance) begin
            if (r_bit_cnt != BIT_MAX) begin
                w_state_d   = DATA;
                w_w_d       = r_sh[DATA_W-1];
                w_valid_d   = 1'b1;
                w_sh_d      = {r_sh[DATA_W-2:0], 1'b0};
                w_bit_cnt_d = r_bit_cnt + 1'b1;
                w_emit      = 1'b1;
                w_emit_bit  = r_sh[DATA_W-1];
            end else if (r_last || !r_hold_full) begin
                // Underrun closes the frame early and flags it.
                w_state_d    = EOF;
                w_flag_cnt_d = FLAG_ONE;
                w_valid_d    = 1'b1;
                w_err_d      = !r_last;
            end else begin
                w_load = 1'b1;
            end
        end

        // Move the held word into the shifter and emit its MSB immediately.
        if (w_load) begin
            w_state_d   = DATA;
            w_w_d       = r_hold[DATA_W-1];
            w_valid_d   = 1'b1;
            w_sh_d      = {r_hold[DATA_W-2:0], 1'b0};
            w_bit_cnt_d = BIT_ONE;
            w_last_d    = r_hold_last;
            w_emit      = 1'b1;
            w_emit_bit  = r_hold[DATA_W-1];
        end
    end

    // Frame state, shifter and registered line outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_flag_cnt <= '0;
            r_sh       <= '0;
            r_bit_cnt  <= '0;
            r_last     <= 1'b0;
            r_w        <= 1'b0;
            r_w_valid  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_flag_cnt <= w_flag_cnt_d;
            r_sh       <= w_sh_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_last     <= w_last_d;
            r_w        <= w_w_d;
            r_w_valid  <= w_valid_d;
            r_err      <= w_err_d;
        end
    end

    // Single-entry holding register; a drain and an accept may share an edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= data_in;
                r_hold_last <= data_last;
            end
            r_hold_full <= (r_hold_full && !w_load) || w_accept;
        end
    end

    assign w       = r_w;
    assign w_valid = r_w_valid;
    assign err     = r_err;
    assign busy    = (r_state != IDLE);
    assign LEDR    = state_led(r_state);

endmodule

// File: tb/tb_sequence_stuff_tx.sv
// Self-checking bench for sequence_stuff_tx: directed frames from the test plan
// plus randomized frames checked against a bit-level framing model.
module tb_sequence_stuff_tx;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_last = 1'b0;
    logic       data_ready;
    logic       w;
    logic       w_valid;
    logic       busy;
    logic       err;
    logic [7:4] LEDR;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state
    bit         cap[$];
    logic [3:0] led_q[$];
    logic [3:0] led_last;
    int         runs;
    int         done;
    int         errs;
    int         err_pos;
    bit         prev_v;

    logic [7:0] wbuf[4];

    sequence_stuff_tx dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_ready (data_ready),
        .w          (w),
        .w_valid    (w_valid),
        .busy       (busy),
        .err        (err),
        .LEDR       (LEDR)
    );

    initial forever #5 Clk = ~Clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line monitor, sampled on the inactive edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (w_valid) cap.push_back(w);
            if (w_valid && !prev_v) runs++;
            if (!w_valid && prev_v) done++;
            if (err) begin
                errs++;
                err_pos = cap.size();
            end
            if (LEDR != led_last) begin
                led_q.push_back(LEDR);
                led_last = LEDR;
            end
            prev_v = w_valid;
        end
    end

    task automatic clear_mon();
        cap.delete();
        led_q.delete();
        led_last = LEDR;
        runs     = 0;
        done     = 0;
        errs     = 0;
        err_pos  = -1;
        prev_v   = w_valid;
    endtask

    function automatic string cap_str();
        string s = "";
        foreach (cap[i]) s = {s, cap[i] ? "1" : "0"};
        return s;
    endfunction

    function automatic string led_str();
        string s = "";
        foreach (led_q[i]) s = {s, $sformatf("%b ", led_q[i])};
        return s;
    endfunction

    // Reference framing: flag of four ones, payload MSB-first with a complement
    // inserted after every third identical bit (stuff bits count), four zeros.
    function automatic string model_str(input int n);
        string s = "1111";
        int    run = 0;
        bit    prev = 1'b0;
        bit    b;
        for (int i = 0; i < n; i++) begin
            for (int k = 7; k >= 0; k--) begin
                b = wbuf[i][k];
                s = {s, b ? "1" : "0"};
                run = (run == 0 || b != prev) ? 1 : run + 1;
                prev = b;
                if (run == 3) begin
                    prev = !prev;
                    s = {s, prev ? "1" : "0"};
                    run = 1;
                end
            end
        end
        return {s, "0000"};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_word(input logic [7:0] d, input logic l);
        int t = 0;
        data_in    = d;
        data_last  = l;
        data_valid = 1'b1;
        while (!data_ready && t < 200) begin
            @(negedge Clk);
            t++;
        end
        n_tests++;
        if (!data_ready) begin
            n_fail++;
            $display("FAIL push_ready: data_ready=%b after %0d cycles, want 1", data_ready, t);
        end
        @(posedge Clk);
        @(negedge Clk);
        data_valid = 1'b0;
        data_last  = 1'b0;
    endtask

    task automatic wait_frame();
        int t = 0;
        while (done == 0 && t < 1000) begin
            @(negedge Clk);
            t++;
        end
        n_tests++;
        if (done == 0) begin
            n_fail++;
            $display("FAIL frame_end: frames ended=%0d, want >=1", done);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        #11;
        n_tests++;
        if (w !== 1'b0) begin n_fail++; $display("FAIL reset_w: got %b want 0", w); end
        n_tests++;
        if (w_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_w_valid: got %b want 0", w_valid);
        end
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++;
        if (LEDR !== 4'b0001) begin
            n_fail++; $display("FAIL reset_ledr: got %b want 0001", LEDR);
        end
        n_tests++;
        if (data_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_low: got %b want 0", data_ready);
        end
        Reset = 1'b1;
        #1;
        n_tests++;
        if (data_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_high: got %b want 1", data_ready);
        end
        @(negedge Clk);
    endtask

    task automatic test_a5(input string tag);
        string s;
        clear_mon();
        push_word(8'hA5, 1'b1);
        // One idle cycle after the accept edge, then the first flag bit.
        n_tests++;
        if (w_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_latency_idle: w_valid=%b want 0", tag, w_valid);
        end
        @(negedge Clk);
        n_tests++;
        if (w !== 1'b1 || w_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_latency_sof: w=%b w_valid=%b want 1 1", tag, w, w_valid);
        end
        wait_frame();
        s = cap_str();
        n_tests++;
        if (s != "1111101001010000") begin
            n_fail++; $display("FAIL %s_bits: got %s want 1111101001010000", tag, s);
        end
        n_tests++;
        if (errs != 0) begin n_fail++; $display("FAIL %s_err: got %0d pulses want 0", tag, errs); end
        n_tests++;
        if (runs != 1) begin n_fail++; $display("FAIL %s_gap: got %0d bursts want 1", tag, runs); end
        s = led_str();
        n_tests++;
        if (s != "0010 0100 1000 0001 ") begin
            n_fail++; $display("FAIL %s_ledr: got %s want 0010 0100 1000 0001", tag, s);
        end
    endtask

    task automatic test_ff();
        string s;
        clear_mon();
        push_word(8'hFF, 1'b1);
        wait_frame();
        s = cap_str();
        n_tests++;
        if (s != "111111101110110000") begin
            n_fail++; $display("FAIL ff_bits: got %s want 111111101110110000", s);
        end
        n_tests++;
        if (errs != 0) begin n_fail++; $display("FAIL ff_err: got %0d pulses want 0", errs); end
    endtask

    task automatic test_00();
        string s;
        clear_mon();
        push_word(8'h00, 1'b1);
        wait_frame();
        s = cap_str();
        n_tests++;
        if (s != "111100010001000000") begin
            n_fail++; $display("FAIL zero_bits: got %s want 111100010001000000", s);
        end
    endtask

    task automatic test_back_to_back();
        string s;
        clear_mon();
        push_word(8'hF0, 1'b0);
        push_word(8'h0F, 1'b1);
        wait_frame();
        s = cap_str();
        n_tests++;
        if (s != "1111111010001000100111010000") begin
            n_fail++; $display("FAIL b2b_bits: got %s want 1111111010001000100111010000", s);
        end
        n_tests++;
        if (runs != 1) begin n_fail++; $display("FAIL b2b_gap: got %0d bursts want 1", runs); end
        n_tests++;
        if (errs != 0) begin n_fail++; $display("FAIL b2b_err: got %0d pulses want 0", errs); end
    endtask

    task automatic test_underrun();
        string s;
        clear_mon();
        push_word(8'h3C, 1'b0);
        wait_frame();
        s = cap_str();
        n_tests++;
        if (s != "11110011101000000") begin
            n_fail++; $display("FAIL underrun_bits: got %s want 11110011101000000", s);
        end
        n_tests++;
        if (errs != 1) begin
            n_fail++; $display("FAIL underrun_err_count: got %0d pulses want 1", errs);
        end
        n_tests++;
        if (err_pos != 14) begin
            n_fail++; $display("FAIL underrun_err_pos: got bit %0d want 14", err_pos);
        end
        n_tests++;
        if (busy !== 1'b0 || LEDR !== 4'b0001) begin
            n_fail++; $display("FAIL underrun_idle: busy=%b LEDR=%b want 0 0001", busy, LEDR);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clear_mon();
        push_word(8'hFF, 1'b1);
        while (cap.size() < 6 && t < 100) begin
            @(negedge Clk);
            t++;
        end
        n_tests++;
        if (LEDR !== 4'b0100) begin
            n_fail++; $display("FAIL midrst_in_data: LEDR=%b want 0100", LEDR);
        end
        #2 Reset = 1'b0;
        #1;
        n_tests++;
        if (w !== 1'b0 || w_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_line: w=%b w_valid=%b want 0 0", w, w_valid);
        end
        n_tests++;
        if (LEDR !== 4'b0001 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: LEDR=%b busy=%b want 0001 0", LEDR, busy);
        end
        @(negedge Clk);
        n_tests++;
        if (errs != 0) begin n_fail++; $display("FAIL midrst_err: got %0d pulses want 0", errs); end
        Reset = 1'b1;
        @(negedge Clk);
        test_a5("after_rst");
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            int    n;
            bit    ur;
            string exp_s;
            string got_s;
            n  = $urandom_range(1, 3);
            ur = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            exp_s = model_str(n);
            clear_mon();
            for (int i = 0; i < n; i++) push_word(wbuf[i], !ur && (i == n - 1));
            wait_frame();
            got_s = cap_str();
            n_tests++;
            if (got_s != exp_s) begin
                n_fail++;
                $display("FAIL rand%0d_bits: n=%0d got %s want %s", f, n, got_s, exp_s);
            end
            n_tests++;
            if (errs != (ur ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand%0d_err: got %0d pulses want %0d", f, errs, ur ? 1 : 0);
            end
            n_tests++;
            if (runs != 1) begin
                n_fail++; $display("FAIL rand%0d_gap: got %0d bursts want 1", f, runs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a5("a5");
        test_ff();
        test_00();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
